duty_ramp_controller: RTL
=========================

Name: duty_ramp_controller

Overview:
- Upstream stage of the fan PWM generator: produces the duty word fed to the PWM counter-value input.
- Slew-limits target duty changes once per PWM period.
- Applies a full-duty kick-start when the fan starts from standstill.
- All decisions are synchronised to the PWM period-restart tick, so the duty only changes between PWM periods.

Parameters:
- COUNTER_BITWIDTH, 4, width of duty word; max duty DMAX = 2^COUNTER_BITWIDTH-1.
- KICK_PERIODS, 3, number of full PWM periods held at DMAX during kick-start (must be >=1).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- clk_en_i  in  1  global clock enable shared with the PWM stage.
- period_tick_i  in  1  PWM period-restart pulse; qualified by clk_en_i.
- enable_i  in  1  fan enable; low forces OFF.
- target_i  in  COUNTER_BITWIDTH  requested duty.
- step_i  in  COUNTER_BITWIDTH  max duty change per tick; 0 = unlimited (jump).
- duty_o  out  COUNTER_BITWIDTH  registered duty to PWM stage.
- state_o  out  2  current state: OFF=0, KICK=1, RAMP=2, TRACK=3.
- at_target_o  out  1  high when state is TRACK.

Behaviour:
- Reset: async on rstn_i low. duty_o=0, state OFF, kick counter=0, at_target_o=0. Reset mid-ramp or mid-kick aborts immediately.
- Update event: a clk_i edge with clk_en_i=1 and period_tick_i=1. duty_o and state are registered; a new value is visible one clk after the event.
- enable_i=0: on the next clk edge (event not required), state OFF, duty_o=0. Overrides every other rule.
- OFF:
  - Event with enable_i=1 and target_i!=0 -> KICK, duty_o=DMAX, kick counter=KICK_PERIODS-1.
  - Otherwise stay OFF with duty 0.
- KICK:
  - Event with counter!=0 -> decrement, duty stays DMAX.
  - Event with counter==0 -> apply slew step toward target_i (from DMAX), go to RAMP. If the result equals target_i, go to TRACK instead.
  - target_i changes during KICK do not shorten the kick.
- RAMP:
  - Each event: duty_o <- slew(duty_o, target_i, step_i).
  - Result == target_i and target_i!=0 -> TRACK.
  - Result == 0 and target_i==0 -> OFF.
- TRACK:
  - Event with target_i!=duty_o -> apply slew step in the same event.
  - Next state follows the RAMP rules: TRACK if the target is reached, OFF if 0, else RAMP.
- Slew arithmetic:
  - Computed in COUNTER_BITWIDTH+1 bits.
  - Up: out = (target-duty <= step) ? target : duty+step.
  - Down: out = (duty-target <= step) ? target : duty-step.
  - Never overshoots, never wraps.
  - step_i==0 -> out=target.
- Between events, target_i and step_i are ignored and duty_o is held.
- Event with target_i==0 in KICK: the kick completes, then ramps down to 0 and ends in OFF.

Optional Feature:
- Macro: DUTY_RAMP_KICKSTART_EN.
- Defined: KICK state and kick counter present, as described above.
- Undefined:
  - KICK is never entered; encoding 1 is unused.
  - OFF event with enable_i=1 and target_i!=0 -> slew step from 0 toward target_i, go to RAMP (or TRACK if reached in one step).
  - KICK_PERIODS is ignored.

Decomposition:
- Shared package fan_ctrl_pkg holds:
  - state encoding localparams (ST_OFF, ST_KICK, ST_RAMP, ST_TRACK);
  - default KICK_PERIODS;
  - default COUNTER_BITWIDTH.
- One combinational sub-module, duty_slew_step: inputs duty, target, step; output next duty with saturation and the step==0 jump rule. Reused by the top in KICK exit, RAMP and TRACK.

Test Plan:
- Reset mid-RAMP (duty 9): rstn_i low between edges -> duty_o=0, state_o=0 immediately. After release, stays OFF until an event.
- Kick (macro on, W=4, KICK_PERIODS=3): enable=1, target=5, step=2.
  - Events t0..t2 -> duty 15, state KICK.
  - t3 -> 13 RAMP; t4 11; t5 9; t6 7; t7 5 TRACK, at_target_o=1.
- Ramp up with saturation: in TRACK at 5, target=14, step=4.
  - Events -> 9, 13, 14 TRACK.
  - Then target=15, step=15 -> 15, no wrap.
- Ramp down to off: TRACK at 6, target=0, step=4 -> 2 RAMP, then 0 OFF. A further event stays OFF (no re-kick while target=0).
- step_i=0 and disable: TRACK at 3, target=12, step=0 -> 12 TRACK on the next event.
  - Drop enable_i between events -> duty_o=0, OFF on the next clk.
  - clk_en_i=0 with period_tick_i=1 -> no update.
- Macro off: enable=1, target=6, step=4 -> OFF->4 RAMP on the first event, 6 TRACK on the second. state_o never equals 1.

Source files
------------

// File: rtl/fan_ctrl_pkg.sv
// Shared definitions for the fan control path.
// Contents: state encodings for the duty ramp FSM (ST_OFF, ST_KICK, ST_RAMP,
// ST_TRACK) and the default duty width and kick-start length.
package fan_ctrl_pkg;

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_KICK  = 2'd1;
    localparam logic [1:0] ST_RAMP  = 2'd2;
    localparam logic [1:0] ST_TRACK = 2'd3;

    localparam int DEF_COUNTER_BITWIDTH = 4;
    localparam int DEF_KICK_PERIODS     = 3;

endpackage

// File: rtl/duty_ramp_if.sv
// Signal bundle between the fan control logic and the duty ramp controller.
// Ports (by modport):
//   master : drives clk_en_i, period_tick_i, enable_i, target_i, step_i;
//            receives duty_o, state_o, at_target_o.
//   slave  : the duty ramp controller side (directions reversed).
interface duty_ramp_if #(
    parameter int W = fan_ctrl_pkg::DEF_COUNTER_BITWIDTH
);
    logic         clk_en_i;
    logic         period_tick_i;
    logic         enable_i;
    logic [W-1:0] target_i;
    logic [W-1:0] step_i;
    logic [W-1:0] duty_o;
    logic [1:0]   state_o;
    logic         at_target_o;

    modport master (
        output clk_en_i, period_tick_i, enable_i, target_i, step_i,
        input  duty_o, state_o, at_target_o
    );

    modport slave (
        input  clk_en_i, period_tick_i, enable_i, target_i, step_i,
        output duty_o, state_o, at_target_o
    );
endinterface

// File: rtl/duty_slew_step.sv
// One slew-limited step of the duty word toward its target.
// Ports:
//   i_duty   : present duty
//   i_target : requested duty
//   i_step   : largest allowed change; 0 means jump straight to the target
//   o_next   : next duty, clamped at the target so it never overshoots or wraps
module duty_slew_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_duty,
    input  logic [W-1:0] i_target,
    input  logic [W-1:0] i_step,
    output logic [W-1:0] o_next
);

    logic [W:0] w_duty;
    logic [W:0] w_target;
    logic [W:0] w_step;
    logic [W:0] w_diff;

    assign w_duty   = {1'b0, i_duty};
    assign w_target = {1'b0, i_target};
    assign w_step   = {1'b0, i_step};

    always_comb begin
        o_next = i_target;
        w_diff = '0;
        if (i_step != '0) begin
            if (w_target >= w_duty) begin
                w_diff = w_target - w_duty;
                // duty+step stays below target here, so truncation is safe
                if (w_diff > w_step) o_next = W'(w_duty + w_step);
            end else begin
                w_diff = w_duty - w_target;
                if (w_diff > w_step) o_next = W'(w_duty - w_step);
            end
        end
    end

endmodule

// File: rtl/duty_ramp_controller.sv
// Duty ramp controller: produces the slew-limited duty word for the fan PWM
// stage, updating only on clock-enabled PWM period ticks.
// Build option: define DUTY_RAMP_KICKSTART_EN to hold full duty for
// KICK_PERIODS periods when starting from standstill; otherwise the ramp
// starts directly from 0.
// Ports:
//   clk_i  : system clock
//   rstn_i : asynchronous active-low reset
//   bus    : duty_ramp_if.slave (clock enable, period tick, enable, target,
//            step in; duty, state, at-target out)
//
// state    | meaning
// ST_OFF   | fan stopped, duty 0
// ST_KICK  | kick-start, duty held at DMAX
// ST_RAMP  | stepping toward target
// ST_TRACK | duty equals target
module duty_ramp_controller #(
    parameter int COUNTER_BITWIDTH = fan_ctrl_pkg::DEF_COUNTER_BITWIDTH,
    parameter int KICK_PERIODS     = fan_ctrl_pkg::DEF_KICK_PERIODS
) (
    input logic        clk_i,
    input logic        rstn_i,
    duty_ramp_if.slave bus
);
    import fan_ctrl_pkg::*;

    localparam int         W    = COUNTER_BITWIDTH;
    localparam logic [W-1:0] DMAX = '1;

    if (KICK_PERIODS < 1) begin : g_bad_kick
        $error("KICK_PERIODS must be at least 1");
    end

    logic [W-1:0] r_duty;
    logic [1:0]   r_state;
    logic [W-1:0] w_slew;
    logic [1:0]   w_settle_state;
    logic         w_event;

    assign w_event = bus.clk_en_i & bus.period_tick_i;

    // In OFF the duty is 0 and in KICK it is DMAX, so the registered duty is
    // always the correct starting point for the step.
    duty_slew_step #(.W(W)) u_slew (
        .i_duty   (r_duty),
        .i_target (bus.target_i),
        .i_step   (bus.step_i),
        .o_next   (w_slew)
    );

    always_comb begin
        if (w_slew == bus.target_i && bus.target_i != '0)
            w_settle_state = ST_TRACK;
        else if (w_slew == '0 && bus.target_i == '0)
            w_settle_state = ST_OFF;
        else
            w_settle_state = ST_RAMP;
    end

`ifdef DUTY_RAMP_KICKSTART_EN
    localparam int           KW        = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
    localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_PERIODS - 1);

    logic [KW-1:0] r_kick_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_kick_cnt <= '0;
        end else if (!bus.enable_i) begin
            r_kick_cnt <= '0;
        end else if (w_event) begin
            if (r_state == ST_OFF && bus.target_i != '0)
                r_kick_cnt <= KICK_LOAD;
            else if (r_state == ST_KICK && r_kick_cnt != '0)
                r_kick_cnt <= r_kick_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_duty  <= '0;
            r_state <= ST_OFF;
        end else if (!bus.enable_i) begin
            r_duty  <= '0;
            r_state <= ST_OFF;
        end else if (w_event) begin
            case (r_state)
                ST_OFF: begin
                    if (bus.target_i != '0) begin
`ifdef DUTY_RAMP_KICKSTART_EN
                        r_duty  <= DMAX;
                        r_state <= ST_KICK;
`else
                        r_duty  <= w_slew;
                        r_state <= w_settle_state;
`endif
                    end
                end
`ifdef DUTY_RAMP_KICKSTART_EN
                ST_KICK: begin
                    if (r_kick_cnt == '0) begin
                        r_duty  <= w_slew;
                        r_state <= w_settle_state;
                    end
                end
`endif
                ST_RAMP: begin
                    r_duty  <= w_slew;
                    r_state <= w_settle_state;
                end
                ST_TRACK: begin
                    if (bus.target_i != r_duty) begin
                        r_duty  <= w_slew;
                        r_state <= w_settle_state;
                    end
                end
                default: begin
                    r_duty  <= '0;
                    r_state <= ST_OFF;
                end
            endcase
        end
    end

    assign bus.duty_o      = r_duty;
    assign bus.state_o     = r_state;
    assign bus.at_target_o = (r_state == ST_TRACK);

endmodule
